// File: rtl/cam_stream_framer.sv
// Camera pixel framer: buffers the incoming byte stream in a small FIFO and tags
// each pixel with start-of-frame / end-of-line / end-of-frame flags.
module cam_stream_framer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       start_pulse,
  input  logic [9:0] ctrlreg_width,
  input  logic [9:0] ctrlreg_height,
  input  logic [7:0] cam_stream_rsc_dat,
  input  logic       cam_stream_rsc_vld,
  output logic       cam_stream_rsc_rdy,
  output logic [7:0] pix_dat,
  output logic       pix_vld,
  input  logic       pix_rdy,
  output logic       pix_sof,
  output logic       pix_eol,
  output logic       pix_eof,
  output logic       frame_done,
  output logic       busy
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic          done_nxt;
  logic [10:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic [9:0]    w, h, col_in, row_in;
  logic          in_done;
  logic          push, pop;
  logic          sof_in, eol_in, eof_in;
  logic          dims_zero;
  logic [10:0]   head;

  // Ready depends only on registered state so the input side never waits on pix_rdy.
  assign cam_stream_rsc_rdy = (state == RUN) && !in_done && (count < FULL);
  assign push      = cam_stream_rsc_vld && cam_stream_rsc_rdy;
  assign pix_vld   = (count != '0);
  assign pop       = pix_vld && pix_rdy;
  assign busy      = (state == RUN);
  assign dims_zero = (ctrlreg_width == 10'd0) || (ctrlreg_height == 10'd0);

  assign sof_in = (col_in == 10'd0) && (row_in == 10'd0);
  assign eol_in = (col_in == w - 10'd1);
  assign eof_in = eol_in && (row_in == h - 10'd1);

  assign head    = mem[rptr];
  assign pix_dat = pix_vld ? head[10:3] : 8'd0;
  assign pix_sof = pix_vld && head[2];
  assign pix_eol = pix_vld && head[1];
  assign pix_eof = pix_vld && head[0];

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start_pulse) begin
          if (dims_zero) done_nxt  = 1'b1;
          else           state_nxt = RUN;
        end
      end
      RUN: begin
        if (pop && head[0]) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state      <= IDLE;
      frame_done <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      col_in     <= '0;
      row_in     <= '0;
      in_done    <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= done_nxt;
      if (state == IDLE && start_pulse) begin
        col_in  <= '0;
        row_in  <= '0;
        in_done <= 1'b0;
      end
      if (push) begin
        wptr <= wptr + 1'b1;
        if (eol_in) begin
          col_in <= '0;
          row_in <= row_in + 10'd1;
        end else begin
          col_in <= col_in + 10'd1;
        end
        if (eof_in) in_done <= 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload and frame geometry carry no reset; they are only observed behind valid state.
  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= {cam_stream_rsc_dat, sof_in, eol_in, eof_in};
    if (state == IDLE && start_pulse) begin
      w <= ctrlreg_width;
      h <= ctrlreg_height;
    end
  end

endmodule

// File: tb/tb_cam_stream_framer.sv
// Scoreboard bench for cam_stream_framer: a reference model tracks accepted pixels
// and expected flags, and every DUT output is compared against it each cycle.
module tb_cam_stream_framer;

  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       start_pulse = 1'b0;
  logic [9:0] ctrlreg_width = '0;
  logic [9:0] ctrlreg_height = '0;
  logic [7:0] cam_stream_rsc_dat = '0;
  logic       cam_stream_rsc_vld = 1'b0;
  logic       cam_stream_rsc_rdy;
  logic [7:0] pix_dat;
  logic       pix_vld;
  logic       pix_rdy = 1'b0;
  logic       pix_sof, pix_eol, pix_eof;
  logic       frame_done;
  logic       busy;

  cam_stream_framer #(.DEPTH(DEPTH), .AW(2)) dut (
    .CLK(CLK), .RESET(RESET), .start_pulse(start_pulse),
    .ctrlreg_width(ctrlreg_width), .ctrlreg_height(ctrlreg_height),
    .cam_stream_rsc_dat(cam_stream_rsc_dat), .cam_stream_rsc_vld(cam_stream_rsc_vld),
    .cam_stream_rsc_rdy(cam_stream_rsc_rdy),
    .pix_dat(pix_dat), .pix_vld(pix_vld), .pix_rdy(pix_rdy),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] dat;
    logic       sof;
    logic       eol;
    logic       eof;
  } ent_t;

  ent_t q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic       m_run = 1'b0;
  logic       m_in_done = 1'b0;
  logic       m_acc = 1'b0;
  logic       exp_done = 1'b0;
  logic [9:0] m_w = '0, m_h = '0, m_col = '0, m_row = '0;

  // Per-run statistics
  int n_out = 0, n_acc = 0, n_sof = 0, n_eol = 0, n_eof = 0, n_done = 0, n_rdy = 0;
  int cyc = 0, first_out = 0, last_out = 0;
  logic [2:0] last_fl = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: compare outputs with the model, then advance the model for the next edge.
  initial begin
    ent_t hd;
    logic er, pop, was_run;
    logic [9:0] wm1, hm1;
    forever begin
      @(negedge CLK);
      cyc++;
      er = m_run && !m_in_done && (q.size() < DEPTH);
      chk("busy", 32'(busy), 32'(m_run));
      chk("in_rdy", 32'(cam_stream_rsc_rdy), 32'(er));
      chk("frame_done", 32'(frame_done), 32'(exp_done));
      if (frame_done) n_done++;
      if (cam_stream_rsc_rdy) n_rdy++;
      chk("pix_vld", 32'(pix_vld), 32'(q.size() != 0));
      if (q.size() != 0) begin
        hd = q[0];
        chk("pix_dat", 32'(pix_dat), 32'(hd.dat));
        chk("pix_flags", 32'({pix_sof, pix_eol, pix_eof}), 32'({hd.sof, hd.eol, hd.eof}));
      end else begin
        chk("idle_out", 32'({pix_dat, pix_sof, pix_eol, pix_eof}), 32'd0);
      end

      if (!RESET) begin
        q.delete();
        m_run = 1'b0; m_in_done = 1'b0; exp_done = 1'b0; m_acc = 1'b0;
        m_col = '0; m_row = '0;
      end else begin
        pop      = (q.size() != 0) && pix_rdy;
        was_run  = m_run;
        exp_done = 1'b0;
        m_acc    = er && cam_stream_rsc_vld;
        if (pop) begin
          hd = q.pop_front();
          n_out++;
          if (n_out == 1) first_out = cyc;
          last_out = cyc;
          n_sof += int'(hd.sof);
          n_eol += int'(hd.eol);
          n_eof += int'(hd.eof);
          last_fl = {hd.sof, hd.eol, hd.eof};
          if (hd.eof) begin
            m_run = 1'b0;
            exp_done = 1'b1;
          end
        end
        if (m_acc) begin
          wm1 = m_w - 10'd1;
          hm1 = m_h - 10'd1;
          hd.dat = cam_stream_rsc_dat;
          hd.sof = (m_col == 10'd0) && (m_row == 10'd0);
          hd.eol = (m_col == wm1);
          hd.eof = hd.eol && (m_row == hm1);
          q.push_back(hd);
          n_acc++;
          if (hd.eol) begin m_col = '0; m_row = m_row + 10'd1; end
          else        m_col = m_col + 10'd1;
          if (hd.eof) m_in_done = 1'b1;
        end
        if (!was_run && start_pulse) begin
          m_w = ctrlreg_width; m_h = ctrlreg_height;
          m_col = '0; m_row = '0; m_in_done = 1'b0;
          if (ctrlreg_width == 10'd0 || ctrlreg_height == 10'd0) exp_done = 1'b1;
          else m_run = 1'b1;
        end
      end
    end
  end

  task automatic clr_stats();
    n_out = 0; n_acc = 0; n_sof = 0; n_eol = 0; n_eof = 0; n_done = 0; n_rdy = 0;
    first_out = 0; last_out = 0; last_fl = '0;
  endtask

  // One driven cycle; data only changes once the previous offer was taken (or not offered).
  task automatic drive(input int vp, input int rp);
    @(posedge CLK); #1;
    if (m_acc || !cam_stream_rsc_vld) cam_stream_rsc_dat = 8'($urandom);
    cam_stream_rsc_vld = ($urandom_range(99) < vp);
    pix_rdy = ($urandom_range(99) < rp);
  endtask

  task automatic start(input int wd, input int ht);
    @(posedge CLK); #1;
    ctrlreg_width = 10'(wd); ctrlreg_height = 10'(ht);
    start_pulse = 1'b1;
    @(posedge CLK); #1;
    start_pulse = 1'b0;
  endtask

  task automatic run_frame(input int wd, input int ht, input int vp, input int rp,
                           input int budget, input bit mid_start);
    int n;
    clr_stats();
    cam_stream_rsc_vld = (vp == 100);
    pix_rdy = (rp == 100);
    start(wd, ht);
    n = 0;
    while (n_done == 0 && n < budget) begin
      drive(vp, rp);
      if (mid_start && n == 3) begin
        ctrlreg_width = 10'd1; ctrlreg_height = 10'd1; start_pulse = 1'b1;
      end else begin
        start_pulse = 1'b0;
      end
      n++;
    end
    start_pulse = 1'b0;
    chk("frame_timeout", 32'(n_done != 0), 32'd1);
    repeat (3) drive(vp, rp);
    chk("n_out", n_out, wd * ht);
    chk("n_acc", n_acc, wd * ht);
    chk("n_sof", n_sof, 1);
    chk("n_eol", n_eol, ht);
    chk("n_eof", n_eof, 1);
    chk("n_done", n_done, 1);
    cam_stream_rsc_vld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset values
    repeat (2) @(posedge CLK);
    @(negedge CLK); #1;
    chk("rst_vld", 32'(pix_vld), 0);
    chk("rst_out", 32'({pix_dat, pix_sof, pix_eol, pix_eof}), 0);
    chk("rst_ctl", 32'({cam_stream_rsc_rdy, frame_done, busy}), 0);
    @(posedge CLK); #1;
    RESET = 1'b1;

    // Basic frame, full rate; pixels keep being offered after eof and a start arrives mid-frame
    run_frame(4, 2, 100, 100, 100, 1'b1);
    chk("basic_rate", last_out - first_out, 7);

    // Backpressure: FIFO fills to DEPTH then ready drops
    clr_stats();
    cam_stream_rsc_vld = 1'b1; pix_rdy = 1'b0;
    start(8, 1);
    repeat (10) drive(100, 0);
    chk("bp_accepted", n_acc, DEPTH);
    @(negedge CLK); #1;
    chk("bp_rdy_low", 32'(cam_stream_rsc_rdy), 0);
    n = 0;
    while (n_done == 0 && n < 100) begin drive(100, 100); n++; end
    chk("bp_timeout", 32'(n_done != 0), 1);
    chk("bp_out", n_out, 8);
    chk("bp_acc", n_acc, 8);
    cam_stream_rsc_vld = 1'b0;

    // Single pixel frame
    run_frame(1, 1, 100, 100, 50, 1'b0);
    chk("one_px_flags", 32'(last_fl), 32'h7);

    // Zero width: immediate done, never ready
    clr_stats();
    cam_stream_rsc_vld = 1'b1;
    start(0, 5);
    repeat (6) drive(100, 100);
    chk("zero_done", n_done, 1);
    chk("zero_rdy", n_rdy, 0);
    chk("zero_acc", n_acc, 0);
    cam_stream_rsc_vld = 1'b0;

    // Reset mid-frame
    clr_stats();
    cam_stream_rsc_vld = 1'b1; pix_rdy = 1'b0;
    start(8, 1);
    n = 0;
    while (n_acc < 3 && n < 50) begin drive(100, 0); n++; end
    @(posedge CLK); #1;
    RESET = 1'b0; cam_stream_rsc_vld = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(negedge CLK); #1;
    chk("mid_rst_vld", 32'(pix_vld), 0);
    chk("mid_rst_out", 32'({pix_dat, pix_sof, pix_eol, pix_eof}), 0);
    chk("mid_rst_ctl", 32'({cam_stream_rsc_rdy, frame_done, busy}), 0);
    run_frame(4, 1, 100, 100, 50, 1'b0);

    // Random handshake
    run_frame(37, 3, 70, 60, 3000, 1'b0);
    run_frame(5, 4, 50, 30, 3000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cam_stream_framer.md
# cam_stream_framer

Downstream consumer of the DMA camera byte stream. Accepts 8-bit pixels on the `cam_stream_rsc_*` valid/ready channel and buffers them in a small FIFO. Tags each pixel with frame position flags (start-of-frame, end-of-line, end-of-frame) derived from `ctrlreg_width` × `ctrlreg_height`, and presents them on a registered pixel output channel for the line-processing stage. Signals frame completion once the last pixel has left the FIFO.

## Interface
- `DEPTH`, default 4: FIFO entries; a power of two, ≥ 2.
- `AW`, default 2: log2(`DEPTH`); pointer width.

Ports:
- `CLK` in 1: single clock; everything is on the rising edge.
- `RESET` in 1: synchronous, active-low reset, sampled on the `CLK` rising edge.
- `start_pulse` in 1: arms one frame; sampled only in IDLE.
- `ctrlreg_width` in 10: pixels per line; latched on an accepted start.
- `ctrlreg_height` in 10: lines per frame; latched on an accepted start.
- `cam_stream_rsc_dat` in 8: input pixel.
- `cam_stream_rsc_vld` in 1: input valid.
- `cam_stream_rsc_rdy` out 1: input ready.
- `pix_dat` out 8: output pixel; 0 when `pix_vld`=0.
- `pix_vld` out 1: output valid.
- `pix_rdy` in 1: output ready from the downstream stage.
- `pix_sof` out 1: first pixel of the frame; gated by `pix_vld`.
- `pix_eol` out 1: last pixel of a line; gated by `pix_vld`.
- `pix_eof` out 1: last pixel of the frame; gated by `pix_vld`.
- `frame_done` out 1: one-cycle pulse after the EOF pixel is popped.
- `busy` out 1: high while in RUN.

## Operation
- State machine: IDLE, RUN.
- **IDLE**
  - `cam_stream_rsc_rdy`=0 and `busy`=0.
  - On `start_pulse`=1, latch `w`=`ctrlreg_width` and `h`=`ctrlreg_height`, and clear `col_in`, `row_in` and `in_done`.
  - If `w`==0 or `h`==0, pulse `frame_done` on the next cycle and stay in IDLE.
  - Otherwise go to RUN.
- **RUN**
  - `busy`=1.
  - `start_pulse` is ignored.
  - Ready rule: `cam_stream_rsc_rdy` = RUN & !`in_done` & (`count` < `DEPTH`).
  - The ready rule is purely from registers; it has no combinational path from `pix_rdy`.
- **Push** (on `vld`&`rdy`): write {dat, sof, eol, eof} at the write pointer, with
  - sof = (`col_in`==0 & `row_in`==0)
  - eol = (`col_in`==`w`-1)
  - eof = eol & (`row_in`==`h`-1)
- **Counter update on push**
  - If eol: `col_in`←0 and `row_in`←`row_in`+1.
  - Otherwise: `col_in`←`col_in`+1.
  - If eof: `in_done`←1, so no further input is accepted this frame.
- **Output channel**
  - `pix_vld` = (`count`≠0).
  - `pix_*` show the FIFO head.
  - Pop on `pix_vld`&`pix_rdy`.
- **Frame completion**: popping an entry with eof=1 causes, on the next edge, state←IDLE and `frame_done`=1 for exactly one cycle.
- **Pointers and count**
  - Pointers are `AW` bits and wrap modulo `DEPTH`.
  - `count` is `AW`+1 bits.
  - Simultaneous push and pop leaves `count` unchanged; both pointers advance.
- **Arithmetic**
  - `w`-1 and `h`-1 are 10-bit.
  - `w`=1: every pixel has eol=1.
  - `w`=`h`=1: the single pixel carries sof, eol and eof together.
- Pixels offered while IDLE, or after `in_done`, are not accepted (ready is 0) and are never dropped silently.

## Timing
- **Reset** (`RESET`=0 at an edge), applied on that edge:
  - State→IDLE.
  - FIFO flushed: pointers and `count` = 0.
  - `col_in`, `row_in` and `in_done` cleared.
  - Outputs: `cam_stream_rsc_rdy`=0, `pix_vld`=0, `pix_dat`=0, `pix_sof`/`pix_eol`/`pix_eof`=0, `frame_done`=0, `busy`=0.
- **Reset mid-frame**: buffered pixels are discarded and no `frame_done` is issued.
- **Start**
  - `start_pulse` at edge N (in IDLE) gives `busy`=1 and `rdy`=1 from cycle N+1.
  - Zero dimensions give `frame_done`=1 in cycle N+1 and `busy` stays 0.
- **Latency**: a pixel accepted at edge N appears on `pix_*` in cycle N+1 if the FIFO was empty.
- **Throughput**: 1 pixel/cycle when `pix_rdy` is held at 1.
- **Full FIFO**: `rdy`=0 in the cycle after `count` reaches `DEPTH`. A pop in that cycle re-raises `rdy` on the following cycle; there is no same-cycle pass-through.
- **Frame end**: EOF popped at edge M gives `frame_done`=1 and `busy`=0 in cycle M+1. A `start_pulse` in cycle M+1 is accepted.
- **Stall**: while `pix_vld`=1 and `pix_rdy`=0, `pix_dat` and the flags are held stable.

## Test plan
- **Basic frame**: `w`=4, `h`=2, `vld` and `pix_rdy` held at 1.
  - Required: 8 pixels out in order, one per cycle.
  - sof on pixel 0; eol on pixels 3 and 7; eof on pixel 7.
  - `frame_done` pulses once, one cycle after pixel 7 is popped.
- **Backpressure**: `DEPTH`=4, `pix_rdy`=0 for 10 cycles with a `w`=8, `h`=1 stream.
  - Required: exactly 4 pixels accepted, then `rdy`=0.
  - On release: all 8 pixels delivered in order with no loss or duplication.
- **Degenerate sizes**
  - `w`=1, `h`=1: one pixel with sof, eol and eof all set.
  - `w`=0, `h`=5: `frame_done` in the cycle after start, `busy`=0, and `rdy` never asserted.
- **Ignored inputs**
  - `start_pulse` mid-frame: no effect on the counters or flags.
  - Pixels offered after eof is accepted: `rdy`=0 and the pixels are not consumed.
- **Reset mid-frame**: assert `RESET`=0 after 3 of 8 pixels.
  - Required: on the next edge all outputs are at their reset values and the FIFO is empty.
  - A new start then produces a fresh sof on its first pixel.
- **Random handshake**: random `vld`/`pix_rdy` over `w`=37, `h`=3.
  - Required: output sequence equals input sequence.
  - 3 eol flags and 1 eof flag.
  - `count` never exceeds `DEPTH`.
